// File: rtl/sniffer_rr.sv
// Multi-port transaction sniffer: command-filtered capture into per-port FIFOs, round-robin merge onto one valid/ready stream.
// Optional per-port saturating drop counters are compiled in with `define SNIFFER_DROP_CNT_EN.
module sniffer_rr #(
  parameter int NPORTS = 4,
  parameter int DATA_W = 32,
  parameter int CMD_W = 4,
  parameter int TAG_W = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [(1<<CMD_W)-1:0] CMD_FILTER = 16'hFFFE,
  localparam int PKT_W = TAG_W + CMD_W + DATA_W,
  localparam int PW = $clog2(NPORTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS*DATA_W-1:0] data_in,
  input  logic [NPORTS*CMD_W-1:0]  cmd_in,
  input  logic [NPORTS*TAG_W-1:0]  tag_in,
  output logic [PKT_W-1:0]         pkt_out,
  output logic [PW-1:0]            pkt_port,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [NPORTS-1:0]        fifo_full
`ifdef SNIFFER_DROP_CNT_EN
  ,
  output logic [NPORTS*16-1:0]     drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [PKT_W-1:0] fifo_mem [NPORTS][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr [NPORTS];
  logic [AW-1:0]    rd_ptr [NPORTS];
  logic [AW:0]      cnt [NPORTS];
  logic [AW:0]      cnt_nx [NPORTS];
  logic [PKT_W-1:0] pkt_p0 [NPORTS];
  logic [NPORTS-1:0] cap_p0, push_p0, pop_p0, nonempty;

  logic [PW-1:0]    rr, rr_nx, gnt, idx;
  logic             load;
  logic [PKT_W-1:0] pkt_p1;
  logic [PW-1:0]    port_p1;
  logic             vld_p1;

  // Stage p0: capture filter and packet assembly per port
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    logic [CMD_W-1:0] cmd;
    assign cmd          = cmd_in[g*CMD_W +: CMD_W];
    assign cap_p0[g]    = (cmd != '0) && CMD_FILTER[cmd];
    assign pkt_p0[g]    = {tag_in[g*TAG_W +: TAG_W], cmd, data_in[g*DATA_W +: DATA_W]};
    assign nonempty[g]  = (cnt[g] != '0);
    assign cnt_nx[g]    = cnt[g] + (AW+1)'(push_p0[g]) - (AW+1)'(pop_p0[g]);
  end

  // The full flag seen here is the pre-edge value, so a same-edge pop never rescues a capture
  assign push_p0 = cap_p0 & ~fifo_full;

  always_comb begin
    gnt = rr;
    idx = '0;
    for (int k = NPORTS-1; k >= 0; k--) begin
      idx = PW'((int'(rr) + k) % NPORTS);
      if (nonempty[idx]) gnt = idx;
    end
    load  = (|nonempty) && (!vld_p1 || pkt_ready);
    rr_nx = (gnt == PW'(NPORTS-1)) ? '0 : gnt + PW'(1);
    for (int p = 0; p < NPORTS; p++) pop_p0[p] = load && (gnt == PW'(p));
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++)
      if (push_p0[p]) fifo_mem[p][wr_ptr[p]] <= pkt_p0[p];
  end

  // Stage p1: FIFO pointers, arbitration pointer and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
      fifo_full <= '0;
      rr        <= '0;
      vld_p1    <= 1'b0;
      pkt_p1    <= '0;
      port_p1   <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (push_p0[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop_p0[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
        cnt[p]       <= cnt_nx[p];
        fifo_full[p] <= (cnt_nx[p] == DEPTH_C);
      end
      if (load) begin
        pkt_p1  <= fifo_mem[gnt][rd_ptr[gnt]];
        port_p1 <= gnt;
        vld_p1  <= 1'b1;
        rr      <= rr_nx;
      end else if (pkt_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign pkt_out   = pkt_p1;
  assign pkt_port  = port_p1;
  assign pkt_valid = vld_p1;

`ifdef SNIFFER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NPORTS-1:0] drop_p0;
  logic [15:0]       dcnt [NPORTS];

  assign drop_p0 = cap_p0 & fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPORTS; p++) dcnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++)
        if (drop_p0[p]) dcnt[p] <= sat_inc16(dcnt[p]);
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_dcnt
    assign drop_cnt[g*16 +: 16] = dcnt[g];
  end
`endif

endmodule
